// File: rtl/led_arb_pkg.sv
// Shared types and the round-robin picker for the LED bank arbiter.
package led_arb_pkg;

  // Widest requester set the picker handles; top-level vectors are widened to this.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Search starts at last_owner+1 and wraps, so last_owner itself is tried last.
  function automatic rr_pick_t rr_pick(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [RR_IDX_W-1:0]   last_owner,
    input int unsigned           num_req
  );
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
      if (k <= num_req && !res.valid) begin
        cand = 32'(last_owner) + k;
        if (cand >= num_req) begin
          cand = cand - num_req;
        end
        if (req[cand[RR_IDX_W-1:0]]) begin
          res.valid = 1'b1;
          res.idx   = cand[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_arbiter_tick_gen.sv
// Free-running prescaler: one-cycle tick strobe every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..DIV-1 and raise the strobe on the wrap.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner arbitration of the LED bank with tick-based forced rotation
// and a one-cycle blank gap between owners. All outputs are registered.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LED_W     = 4,
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int MAX_TICKS = 1000
) (
  input  logic                          sys_clk_50m,
  input  logic                          sys_rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][LED_W-1:0] req_leds,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [LED_W-1:0]              leds,
  output logic                          busy
);

  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam int TICK_W  = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;
  localparam logic [TICK_W-1:0] MAX_TICKS_C = TICK_W'(MAX_TICKS);
  localparam logic [OWNER_W-1:0] OWNER_RST  = OWNER_W'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [OWNER_W-1:0]  last_owner_q, last_owner_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic                busy_q, busy_d;

  logic                tick;
  rr_pick_t            pick;
  logic [TICK_W-1:0]   tick_cnt_inc;
  logic [NUM_REQ-1:0]  owner_mask;
  logic                owner_req;
  logic                others_req;
  logic                preempt;
  logic                unused_pick_bits;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk   (sys_clk_50m),
    .rst_n (sys_rst_n),
    .tick  (tick)
  );

  // Next winner if arbitration happens this cycle.
  always_comb begin
    pick = rr_pick(RR_MAX_REQ'(req), RR_IDX_W'(last_owner_q), NUM_REQ);
  end

  // Upper index bits are always zero for NUM_REQ <= 2**OWNER_W; fold them away.
  assign unused_pick_bits = ^pick.idx;

  // Saturating tick count and the forced-rotation decision. Preemption fires on
  // the edge where the count reaches MAX_TICKS, not one cycle after.
  always_comb begin
    tick_cnt_inc = tick_cnt_q;
    if (tick && (tick_cnt_q < MAX_TICKS_C)) begin
      tick_cnt_inc = tick_cnt_q + TICK_W'(1);
    end
    owner_mask = NUM_REQ'(1) << last_owner_q;
    owner_req  = |(req & owner_mask);
    others_req = |(req & ~owner_mask);
    preempt    = (MAX_TICKS != 0) && (tick_cnt_inc >= MAX_TICKS_C) && others_req;
  end

  // FSM next state; last_owner doubles as the current owner while in GRANT.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    tick_cnt_d   = tick_cnt_q;
    case (state_q)
      ARB_IDLE, ARB_GAP: begin
        if (pick.valid) begin
          state_d      = ARB_GRANT;
          last_owner_d = pick.idx[OWNER_W-1:0];
          tick_cnt_d   = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        tick_cnt_d = tick_cnt_inc;
        if (!owner_req || preempt) begin
          state_d = ARB_GAP;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state so they register cleanly.
  always_comb begin
    gnt_d  = '0;
    leds_d = '0;
    busy_d = 1'b0;
    if (state_d == ARB_GRANT) begin
      gnt_d  = NUM_REQ'(1) << last_owner_d;
      leds_d = req_leds[last_owner_d];
      busy_d = 1'b1;
    end
  end

  // State and output registers; reset drops the LEDs without waiting for a clock.
  always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWNER_RST;
      tick_cnt_q   <= '0;
      gnt_q        <= '0;
      leds_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      tick_cnt_q   <= tick_cnt_d;
      gnt_q        <= gnt_d;
      leds_q       <= leds_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign leds = leds_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter: tick every 10 cycles, 2-tick grant limit.
module tb_led_arbiter;

  logic                 clk;
  logic                 rst_n;
  logic [3:0]           req;
  logic [3:0][3:0]      req_leds;
  logic [3:0]           gnt;
  logic [3:0]           leds;
  logic                 busy;

  int tests_run;
  int tests_failed;

  led_arbiter #(
    .NUM_REQ   (4),
    .LED_W     (4),
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .MAX_TICKS (2)
  ) dut (
    .sys_clk_50m (clk),
    .sys_rst_n   (rst_n),
    .req         (req),
    .req_leds    (req_leds),
    .gnt         (gnt),
    .leds        (leds),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] exp_gnt,
                            input logic [3:0] exp_leds, input logic exp_busy);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check_eq({tag, "_leds"}, 32'(leds), 32'(exp_leds));
    check_eq({tag, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_idle();
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check_outs("idle", 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    logic [3:0] rot_seq [5];
    logic [3:0] rot_leds [5];
    int len;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = 4'b0000;
    for (int i = 0; i < 4; i++) req_leds[i] = 4'(i + 1);
    rot_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_leds = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};

    // 1. Idle after reset
    repeat (2) @(negedge clk);
    check_outs("in_reset", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check_outs("idle50", 4'b0000, 4'b0000, 1'b0);
    end
    $display("[TB] idle after reset: 50 cycles checked");

    // 2. Simultaneous requests, voluntary release, one-cycle gap
    req = 4'b0101;
    @(negedge clk);
    check_outs("sim_first", 4'b0001, 4'b0001, 1'b1);
    req = 4'b0100;
    @(negedge clk);
    check_outs("rel_gap", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    check_outs("rel_next", 4'b0100, 4'b0011, 1'b1);
    $display("[TB] release: gnt=%b leds=%b after one gap cycle", gnt, leds);

    // 3. Rotation with all requesting, fresh round-robin pointer
    do_reset();
    req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_eq("rot_gnt", 32'(gnt), 32'(rot_seq[k]));
      check_eq("rot_leds", 32'(leds), 32'(rot_leds[k]));
      if (k < 4) begin
        len = 0;
        while (gnt == rot_seq[k] && len < 40) begin
          len++;
          @(negedge clk);
        end
        check_eq("rot_len_in_11_20", 32'(len >= 11 && len <= 20), 32'd1);
        check_outs("rot_gap", 4'b0000, 4'b0000, 1'b0);
        $display("[TB] rotation: gnt=%b held %0d cycles", rot_seq[k], len);
        @(negedge clk);
      end
    end

    // 4. Sole requester is never preempted
    go_idle();
    req = 4'b0010;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_outs("sole", 4'b0010, 4'b0010, 1'b1);
    end
    $display("[TB] sole requester: 100 cycles held");

    // 5. Asynchronous reset mid-grant
    go_idle();
    req = 4'b0100;
    @(negedge clk);
    check_outs("pre_rst", 4'b0100, 4'b0011, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 4'b0000, 4'b0000, 1'b0);
    req = 4'b1100;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post_rst", 4'b0100, 4'b0011, 1'b1);
    $display("[TB] async reset: post-release gnt=%b", gnt);

    // 6. Single-cycle request pulse
    go_idle();
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    check_outs("pulse_gnt", 4'b1000, 4'b0100, 1'b1);
    @(negedge clk);
    check_outs("pulse_gap", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    check_outs("pulse_idle", 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    check_outs("pulse_idle2", 4'b0000, 4'b0000, 1'b0);
    $display("[TB] pulse: one-cycle grant then gap then idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
